instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
- Encoder side of the MIPS instruction format our Decoder consumes.
- Accepts symbolic instruction descriptors over a valid/ready handshake, packs them into 32-bit MIPS words, and writes them sequentially into instruction memory through a single write port.
- Used by the testbench/boot loader to build programs in Instr_Memory without hand-assembled hex.

Parameters:
- DEPTH_W, 8: word-index width. Capacity is 2^DEPTH_W words. Legal range 2..15.
- BASE_ADDR, 32'h0000_0000: byte address of word index 0. Must be word-aligned.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  pulse. Clears index/error and begins a program. Honoured only in IDLE, DONE and ERR.
- in_valid_i  in  1  descriptor valid.
- in_ready_o  out  1  descriptor accepted when in_valid_i && in_ready_o.
- kind_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SRA, 6 SRAV, 7 ADDI, 8 SLTIU, 9 LUI, 10 ORI, 11 BEQ, 12 BNE, 13 LW, 14 SW, 15 J.
- rs_i, rt_i, rd_i, shamt_i  in  5 each  register and shift fields.
- imm_i  in  16  immediate for I-type arithmetic and LW/SW.
- target_i  in  DEPTH_W  absolute word index for BEQ/BNE/J.
- last_i  in  1  marks the final descriptor of the program.
- mem_we_o  out  1  one-cycle write strobe.
- mem_addr_o  out  32  byte address = BASE_ADDR + 4*idx.
- mem_data_o  out  32  encoded word.
- count_o  out  DEPTH_W+1  number of words written since start_i.
- busy_o  out  1  high in RUN and WRITE.
- done_o  out  1  high in DONE.
- err_o  out  2  0 none, 1 illegal descriptor, 2 overflow. Sticky until start_i or reset.

Behaviour:
- States: IDLE, RUN, WRITE, DONE, ERR.
- Reset (any state, including mid-write): state IDLE, idx=0, count_o=0, err_o=0, and mem_we_o, in_ready_o, busy_o, done_o all 0. mem_addr_o=BASE_ADDR, mem_data_o=0.
- IDLE/DONE/ERR + start_i: idx=0, count_o=0, err_o=0, go to RUN. start_i in RUN/WRITE is ignored.
- RUN: in_ready_o=1. On accept, register the encoded word and address, then go to WRITE. Accept-to-strobe latency is 1 cycle.
- WRITE: mem_we_o=1 for exactly this cycle and in_ready_o=0, so throughput is 1 word per 2 cycles. Then idx++ and count_o++.
  - If the accepted descriptor had last_i, go to DONE.
  - Else if idx wrapped to 0 (capacity exhausted), set err_o=2 and go to ERR.
  - Else go to RUN.
- R-type encoding (op=0): {6'h00, rs, rt, rd, shamt, funct}.
  - funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, SRA 0x03, SRAV 0x07.
  - shamt_i is used only for SRA; all other R-types force shamt=0. SRA forces rs=0.
- I-type encoding: {op, rs, rt, imm}.
  - op: ADDI 0x08, SLTIU 0x0B, LUI 0x0F, ORI 0x0D, LW 0x23, SW 0x2B.
  - LUI forces rs=0.
- Branch encoding: BEQ op 0x04, BNE op 0x05.
  - imm = target_i - (idx+1), computed in signed DEPTH_W+1 bits and sign-extended to 16 bits. Always representable given DEPTH_W ≤ 15.
- J encoding: {6'h02, low 26 bits of (BASE_ADDR>>2) + target_i}.
- Illegal descriptors: BEQ/BNE/J with target_i ≥ 2^DEPTH_W cannot occur, because target_i is DEPTH_W bits wide. Reserved kind 15 is J, so there are no illegal kinds. However, rd_i=0 on any R-type is illegal: the word is not written, err_o=1, next state ERR, count_o unchanged.
- last_i on an illegal descriptor still goes to ERR; ERR takes priority over DONE.
- Capacity boundary: the 2^DEPTH_W-th word with last_i=1 goes to DONE with err_o=0. Without last_i it is written, then ERR with err_o=2.
- mem_addr_o and mem_data_o hold their last values outside WRITE.
- count_o saturates naturally at 2^DEPTH_W and never wraps.

Test Plan:
- Basic encoding: reset, start_i, then ADDI rs0 rt1 imm5 (last=0), then ADD rs1 rt2 rd3.
  - Writes 0x20010005 at 0x0 and 0x00221820 at 0x4.
  - Each mem_we_o pulse occurs 1 cycle after its accept.
- Backward branch: at idx 2, BEQ rs1 rt2 target 0 -> 0x1022FFFD written at 0x8.
- Mixed kinds, last_i handling: SRA rt2 rd4 shamt3 -> 0x000220C3. LW rs1 rt2 imm8 -> 0x8C220008. J target 5 with last_i -> 0x08000005. Then done_o=1 and count_o=3.
- Overflow: DEPTH_W=2, five descriptors with no last_i.
  - Four writes, at addresses 0x0, 0x4, 0x8, 0xC.
  - Then err_o=2 and in_ready_o=0; the fifth descriptor is never accepted.
- Illegal R-type: ADD with rd=0 -> no mem_we_o, err_o=1, count_o unchanged. A subsequent start_i clears err_o and the next write lands at BASE_ADDR.
- Reset mid-write: assert rst_i during the WRITE cycle.
  - Next cycle all outputs are at their reset values and in_ready_o=0.
  - start_i is required before any further accept.

Source files
------------

// File: rtl/instr_stream_encoder_if.sv
// instr_stream_encoder_if: descriptor handshake plus instruction-memory write port
interface instr_stream_encoder_if #(parameter int DEPTH_W = 8);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [3:0]         kind_i;
    logic [4:0]         rs_i;
    logic [4:0]         rt_i;
    logic [4:0]         rd_i;
    logic [4:0]         shamt_i;
    logic [15:0]        imm_i;
    logic [DEPTH_W-1:0] target_i;
    logic               last_i;
    logic               mem_we_o;
    logic [31:0]        mem_addr_o;
    logic [31:0]        mem_data_o;
    modport slave (
        input  in_valid_i, kind_i, rs_i, rt_i, rd_i, shamt_i, imm_i, target_i, last_i,
        output in_ready_o, mem_we_o, mem_addr_o, mem_data_o
    );
    modport master (
        output in_valid_i, kind_i, rs_i, rt_i, rd_i, shamt_i, imm_i, target_i, last_i,
        input  in_ready_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: packs symbolic descriptors into MIPS words and writes them sequentially to instruction memory
module instr_stream_encoder #(
    parameter int          DEPTH_W   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    instr_stream_encoder_if.slave bus,
    output logic [DEPTH_W:0]     count_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           err_o
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_WRITE, S_DONE, S_ERR} state_t;
    state_t             r_state, w_next;
    logic [DEPTH_W-1:0] r_idx;
    logic [DEPTH_W:0]   r_count;
    logic [1:0]         r_err;
    logic               r_last;
    logic [31:0]        r_addr, r_data, w_word, w_jt;
    logic [DEPTH_W:0]   w_off;
    logic [15:0]        w_bimm;
    logic               w_accept, w_illegal, w_start;
    assign w_accept  = bus.in_valid_i && r_state == S_RUN;
    assign w_illegal = bus.kind_i < 4'd7 && bus.rd_i == 5'd0;
    assign w_start   = start_i && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    // Branch offset is relative to the slot after the branch, sign-extended from DEPTH_W+1 bits
    assign w_off  = {1'b0, bus.target_i} - {1'b0, r_idx} - (DEPTH_W+1)'(1);
    assign w_bimm = 16'($signed(w_off));
    assign w_jt   = (BASE_ADDR >> 2) + 32'(bus.target_i);
    always_comb begin
        w_word = '0;
        case (bus.kind_i)
            4'd0:  w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h20};
            4'd1:  w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h22};
            4'd2:  w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h24};
            4'd3:  w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h25};
            4'd4:  w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h2A};
            4'd5:  w_word = {6'h00, 5'd0, bus.rt_i, bus.rd_i, bus.shamt_i, 6'h03};
            4'd6:  w_word = {6'h00, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'h07};
            4'd7:  w_word = {6'h08, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd8:  w_word = {6'h0B, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd9:  w_word = {6'h0F, 5'd0, bus.rt_i, bus.imm_i};
            4'd10: w_word = {6'h0D, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd11: w_word = {6'h04, bus.rs_i, bus.rt_i, w_bimm};
            4'd12: w_word = {6'h05, bus.rs_i, bus.rt_i, w_bimm};
            4'd13: w_word = {6'h23, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd14: w_word = {6'h2B, bus.rs_i, bus.rt_i, bus.imm_i};
            default: w_word = {6'h02, w_jt[25:0]};
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: w_next = w_start ? S_RUN : r_state;
            S_RUN:   w_next = bus.in_valid_i ? (w_illegal ? S_ERR : S_WRITE) : S_RUN;
            S_WRITE: w_next = r_last ? S_DONE : (&r_idx ? S_ERR : S_RUN);
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx   <= '0;
            r_count <= '0;
            r_err   <= 2'd0;
            r_last  <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_data  <= '0;
        end else begin
            if (w_start) begin
                r_idx   <= '0;
                r_count <= '0;
                r_err   <= 2'd0;
            end
            if (w_accept && w_illegal) r_err <= 2'd1;
            if (w_accept && !w_illegal) begin
                r_data <= w_word;
                r_addr <= BASE_ADDR + 32'({r_idx, 2'b00});
                r_last <= bus.last_i;
            end
            if (r_state == S_WRITE) begin
                r_idx   <= r_idx + DEPTH_W'(1);
                r_count <= r_count + (DEPTH_W+1)'(1);
                if (!r_last && &r_idx) r_err <= 2'd2;
            end
        end
    end
    assign bus.in_ready_o = r_state == S_RUN;
    assign bus.mem_we_o   = r_state == S_WRITE;
    assign bus.mem_addr_o = r_addr;
    assign bus.mem_data_o = r_data;
    assign count_o        = r_count;
    assign busy_o         = r_state == S_RUN || r_state == S_WRITE;
    assign done_o         = r_state == S_DONE;
    assign err_o          = r_err;
endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb_instr_stream_encoder: directed and randomized descriptor streams checked against an arithmetic encoding model
module tb_instr_stream_encoder;
    localparam int FN[7]  = '{32, 34, 36, 37, 42, 3, 7};
    localparam int OP[16] = '{0, 0, 0, 0, 0, 0, 0, 8, 11, 15, 13, 4, 5, 35, 43, 2};
    logic clk = 0, rst = 1, start = 0, start_s = 0;
    always #5 clk = ~clk;
    logic [8:0] count;
    logic [2:0] count_s;
    logic       busy, done, busy_s, done_s;
    logic [1:0] err, err_s;
    instr_stream_encoder_if #(.DEPTH_W(8)) bi();
    instr_stream_encoder_if #(.DEPTH_W(2)) si();
    instr_stream_encoder #(.DEPTH_W(8), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bi.slave),
        .count_o(count), .busy_o(busy), .done_o(done), .err_o(err)
    );
    instr_stream_encoder #(.DEPTH_W(2), .BASE_ADDR(32'h0)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start_s), .bus(si.slave),
        .count_o(count_s), .busy_o(busy_s), .done_o(done_s), .err_o(err_s)
    );
    int vectors = 0, miscompares = 0;
    int m_idx = 0, m_count = 0;
    logic [31:0] last_data;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] model(input int k, rs, rt, rd, sh, imm, tgt, idx);
        if (k < 7)
            return (32'(k == 5 ? 0 : rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11)
                 | (32'(k == 5 ? sh : 0) << 6) | 32'(FN[k]);
        if (k == 15)
            return (32'd2 << 26) | (32'(tgt) & 32'h03FF_FFFF);
        return (32'(OP[k]) << 26) | (32'(k == 9 ? 0 : rs) << 21) | (32'(rt) << 16)
             | ((k == 11 || k == 12) ? 32'((tgt - idx - 1) & 'hFFFF) : 32'(imm));
    endfunction
    task automatic drive(input int k, rs, rt, rd, sh, imm, tgt, input bit last);
        bi.kind_i = 4'(k); bi.rs_i = 5'(rs); bi.rt_i = 5'(rt); bi.rd_i = 5'(rd);
        bi.shamt_i = 5'(sh); bi.imm_i = 16'(imm); bi.target_i = 8'(tgt);
        bi.last_i = last; bi.in_valid_i = 1;
    endtask
    task automatic send(input int k, rs, rt, rd, sh, imm, tgt, input bit last);
        int n = 0;
        bit illegal = k < 7 && rd == 0;
        logic [31:0] exp = model(k, rs, rt, rd, sh, imm, tgt, m_idx);
        drive(k, rs, rt, rd, sh, imm, tgt, last);
        while (!bi.in_ready_o && n < 8) begin @(negedge clk); n++; end
        chk("in_ready", 32'(bi.in_ready_o), 1);
        @(negedge clk);
        bi.in_valid_i = 0;
        if (illegal) begin
            chk("illegal_we", 32'(bi.mem_we_o), 0);
            chk("illegal_err", 32'(err), 1);
            chk("illegal_count", 32'(count), 32'(m_count));
        end else begin
            chk("we", 32'(bi.mem_we_o), 1);
            chk("addr", bi.mem_addr_o, 32'(4 * m_idx));
            chk("data", bi.mem_data_o, exp);
            last_data = bi.mem_data_o;
            @(negedge clk);
            m_idx++; m_count++;
            chk("we_low", 32'(bi.mem_we_o), 0);
            chk("count", 32'(count), 32'(m_count));
            if (last) begin
                chk("done", 32'(done), 1);
                chk("err_none", 32'(err), 0);
            end else chk("busy", 32'(busy), 1);
        end
    endtask
    task automatic do_start();
        start = 1;
        @(negedge clk);
        start = 0;
        m_idx = 0; m_count = 0;
        chk("start_count", 32'(count), 0);
        chk("start_err", 32'(err), 0);
        chk("start_ready", 32'(bi.in_ready_o), 1);
    endtask
    initial begin
        bi.in_valid_i = 0; bi.kind_i = 0; bi.rs_i = 0; bi.rt_i = 0; bi.rd_i = 0;
        bi.shamt_i = 0; bi.imm_i = 0; bi.target_i = 0; bi.last_i = 0;
        si.in_valid_i = 0; si.kind_i = 4'd7; si.rs_i = 0; si.rt_i = 0; si.rd_i = 0;
        si.shamt_i = 0; si.imm_i = 0; si.target_i = 0; si.last_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(bi.mem_we_o), 0);
        chk("rst_ready", 32'(bi.in_ready_o), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_addr", bi.mem_addr_o, 0);
        chk("rst_data", bi.mem_data_o, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_ready", 32'(bi.in_ready_o), 0);
        do_start();
        send(7, 0, 1, 0, 0, 5, 0, 0);  chk("addi_word", last_data, 32'h2001_0005);
        send(0, 1, 2, 3, 0, 0, 0, 0);  chk("add_word", last_data, 32'h0022_1820);
        send(11, 1, 2, 0, 0, 0, 0, 1); chk("beq_word", last_data, 32'h1022_FFFD);
        do_start();
        send(5, 9, 2, 4, 3, 0, 0, 0);  chk("sra_word", last_data, 32'h0002_20C3);
        send(13, 1, 2, 0, 0, 8, 0, 0); chk("lw_word", last_data, 32'h8C22_0008);
        send(15, 0, 0, 0, 0, 0, 5, 1); chk("j_word", last_data, 32'h0800_0005);
        chk("prog2_count", 32'(count), 3);
        do_start();
        send(0, 1, 2, 3, 0, 0, 0, 0);
        send(0, 1, 2, 0, 0, 0, 0, 1);
        chk("illegal_done", 32'(done), 0);
        chk("illegal_ready", 32'(bi.in_ready_o), 0);
        do_start();
        send(3, 4, 5, 6, 0, 0, 0, 1);
        do_start();
        for (int i = 0; i < 24; i++) begin
            int k = $urandom_range(0, 15);
            send(k, $urandom_range(0, 31), $urandom_range(0, 31),
                 k < 7 ? $urandom_range(1, 31) : $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 255), i == 23);
        end
        do_start();
        drive(8, 1, 2, 0, 0, 7, 0, 0);
        @(negedge clk);
        chk("mid_we", 32'(bi.mem_we_o), 1);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_we", 32'(bi.mem_we_o), 0);
        chk("mid_rst_ready", 32'(bi.in_ready_o), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_addr", bi.mem_addr_o, 0);
        chk("mid_rst_data", bi.mem_data_o, 0);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(bi.in_ready_o), 0);
            chk("post_rst_we", 32'(bi.mem_we_o), 0);
        end
        bi.in_valid_i = 0;
        do_start();
        send(8, 1, 2, 0, 0, 7, 0, 1);
        for (int p = 0; p < 2; p++) begin
            start_s = 1;
            @(negedge clk);
            start_s = 0;
            chk("s_start_count", 32'(count_s), 0);
            for (int i = 0; i < 4; i++) begin
                si.rt_i = 5'(i); si.imm_i = 16'(i + 1); si.last_i = p == 1 && i == 3;
                si.in_valid_i = 1;
                @(negedge clk);
                si.in_valid_i = 0;
                chk("s_we", 32'(si.mem_we_o), 1);
                chk("s_addr", si.mem_addr_o, 32'(4 * i));
                chk("s_data", si.mem_data_o, model(7, 0, i, 0, 0, i + 1, 0, i));
                @(negedge clk);
            end
            chk("s_count", 32'(count_s), 4);
            chk("s_err", 32'(err_s), p == 0 ? 2 : 0);
            chk("s_done", 32'(done_s), p == 0 ? 0 : 1);
            chk("s_ready", 32'(si.in_ready_o), 0);
            si.in_valid_i = 1;
            repeat (4) begin
                @(negedge clk);
                chk("s_no_accept", 32'(si.mem_we_o), 0);
            end
            si.in_valid_i = 0;
            chk("s_count_hold", 32'(count_s), 4);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
